// File: rtl/twiddle_gen.sv
// Twiddle-factor pair generator: streams (omega^(2k), omega^(2k+1)) mod Q for k = 0..count-1.
// Optional macro TWIDDLE_IDX_EN adds a pair_idx output carrying k alongside each pair.
module twiddle_gen #(
  parameter int WIDTH = 18,
  parameter int Q     = 12289,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] omega,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] weight_1,
  output logic [WIDTH-1:0] weight_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef TWIDDLE_IDX_EN
  ,
  output logic [CNT_W-1:0] pair_idx
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);
  localparam logic [PW-1:0]    Q_P = PW'(Q);

  typedef enum logic [2:0] {IDLE, LOAD, SQ_MUL, SQ_RED, OUT, MUL, RED, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] omega_raw, omega_r, omega2, acc_e, acc_o;
  logic [CNT_W-1:0] count_r, k;
  logic [PW-1:0]    prod_e, prod_o;
  logic             last_pair;

  assign last_pair = (k + CNT_W'(1)) == count_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD:   state_next = (count_r == '0) ? DONE : SQ_MUL;
      SQ_MUL: state_next = SQ_RED;
      SQ_RED: state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = last_pair ? DONE : MUL;
      end
      MUL:  state_next = RED;
      RED:  state_next = OUT;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Products are kept at full 2*WIDTH width and reduced a cycle later to split the long path.
  always_ff @(posedge clk) begin
    if (rst) begin
      omega_raw <= '0;
      omega_r   <= '0;
      omega2    <= '0;
      acc_e     <= '0;
      acc_o     <= '0;
      count_r   <= '0;
      k         <= '0;
      prod_e    <= '0;
      prod_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            omega_raw <= omega;
            count_r   <= count;
          end
        end
        LOAD: begin
          omega_r <= omega_raw % Q_W;
          acc_e   <= WIDTH'(1);
          k       <= '0;
        end
        SQ_MUL: prod_e <= PW'(omega_r) * PW'(omega_r);
        SQ_RED: begin
          omega2 <= WIDTH'(prod_e % Q_P);
          acc_o  <= omega_r;
        end
        OUT: begin
          if (out_ready) k <= k + CNT_W'(1);
        end
        MUL: begin
          prod_e <= PW'(acc_e) * PW'(omega2);
          prod_o <= PW'(acc_o) * PW'(omega2);
        end
        RED: begin
          acc_e <= WIDTH'(prod_e % Q_P);
          acc_o <= WIDTH'(prod_o % Q_P);
        end
        default: ;
      endcase
    end
  end

  assign weight_1 = acc_e;
  assign weight_2 = acc_o;

`ifdef TWIDDLE_IDX_EN
  assign pair_idx = k;
`endif

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed self-checking bench for twiddle_gen (default parameters, Q = 12289).
// Cycle numbering: the cycle in which start is driven high is cycle 0.
module tb_twiddle_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [17:0] omega;
  logic [9:0]  count;
  logic [17:0] weight_1, weight_2;
  logic        out_valid, out_ready, busy, done;
`ifdef TWIDDLE_IDX_EN
  logic [9:0]  pair_idx;
`endif

  int total = 0;
  int bad   = 0;
  int exp_w1 [4];
  int exp_w2 [4];

  twiddle_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .omega     (omega),
    .count     (count),
    .weight_1  (weight_1),
    .weight_2  (weight_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef TWIDDLE_IDX_EN
    ,
    .pair_idx  (pair_idx)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0d expected 0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
    if (done !== 1'b0)      begin bad++; $display("[TB] FAIL reset_done: got %0d expected 0", done); end
    if (weight_1 !== 18'd0) begin bad++; $display("[TB] FAIL reset_w1: got %0d expected 0", weight_1); end
    if (weight_2 !== 18'd0) begin bad++; $display("[TB] FAIL reset_w2: got %0d expected 0", weight_2); end
    rst = 1'b0;
    start = 1'b0;
    tick();
  endtask

  // Full-throughput stream; expected pairs come from exp_w1/exp_w2.
  task automatic test_stream(input string name, input int om, input int cnt);
    int n;
    int nd;
    n = 0;
    nd = 0;
    out_ready = 1'b1;
    omega = 18'(om);
    count = 10'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid) begin
        if (n < cnt) begin
          total += 3;
          if (weight_1 !== 18'(exp_w1[n])) begin bad++; $display("[TB] FAIL %s_w1[%0d]: got %0d expected %0d", name, n, weight_1, exp_w1[n]); end
          if (weight_2 !== 18'(exp_w2[n])) begin bad++; $display("[TB] FAIL %s_w2[%0d]: got %0d expected %0d", name, n, weight_2, exp_w2[n]); end
          if (c != 4 + 3 * n) begin bad++; $display("[TB] FAIL %s_valid_cycle[%0d]: got %0d expected %0d", name, n, c, 4 + 3 * n); end
`ifdef TWIDDLE_IDX_EN
          total++;
          if (pair_idx !== 10'(n)) begin bad++; $display("[TB] FAIL %s_idx[%0d]: got %0d expected %0d", name, n, pair_idx, n); end
`endif
        end
        n++;
      end
      if (done) begin
        nd++;
        total++;
        if (c != 3 * cnt + 2) begin bad++; $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", name, c, 3 * cnt + 2); end
      end
      tick();
    end
    total += 2;
    if (n != cnt) begin bad++; $display("[TB] FAIL %s_pairs: got %0d expected %0d", name, n, cnt); end
    if (nd != 1)  begin bad++; $display("[TB] FAIL %s_done_count: got %0d expected 1", name, nd); end
  endtask

  task automatic test_count_zero();
    int nv;
    nv = 0;
    omega = 18'd5;
    count = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (out_valid) nv++;
      total += 2;
      if (busy !== ((c == 1 || c == 2) ? 1'b1 : 1'b0)) begin bad++; $display("[TB] FAIL zero_busy@%0d: got %0d expected %0d", c, busy, (c == 1 || c == 2)); end
      if (done !== ((c == 2) ? 1'b1 : 1'b0))           begin bad++; $display("[TB] FAIL zero_done@%0d: got %0d expected %0d", c, done, (c == 2)); end
      tick();
    end
    total++;
    if (nv != 0) begin bad++; $display("[TB] FAIL zero_valid: got %0d expected 0", nv); end
  endtask

  // Ready held low for cycles 4..8; stray starts while busy and in DONE.
  task automatic test_backpressure();
    int n;
    int nd;
    int nv;
    n = 0;
    nd = 0;
    nv = 0;
    exp_w1[0] = 1; exp_w2[0] = 3;
    exp_w1[1] = 9; exp_w2[1] = 27;
    omega = 18'd3;
    count = 10'd2;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      out_ready = (c >= 9);
      start = (c == 5 || c == 13);
      omega = (c == 5) ? 18'd7 : 18'd3;
      count = (c == 5) ? 10'd1 : 10'd2;
      if (out_valid) begin
        nv++;
        if (n < 2) begin
          total += 2;
          if (weight_1 !== 18'(exp_w1[n])) begin bad++; $display("[TB] FAIL bp_w1@%0d: got %0d expected %0d", c, weight_1, exp_w1[n]); end
          if (weight_2 !== 18'(exp_w2[n])) begin bad++; $display("[TB] FAIL bp_w2@%0d: got %0d expected %0d", c, weight_2, exp_w2[n]); end
        end
        if (out_ready) begin
          total++;
          if (c != ((n == 0) ? 9 : 12)) begin bad++; $display("[TB] FAIL bp_hs_cycle[%0d]: got %0d expected %0d", n, c, (n == 0) ? 9 : 12); end
          n++;
        end
      end
      if (done) begin
        nd++;
        total++;
        if (c != 13) begin bad++; $display("[TB] FAIL bp_done_cycle: got %0d expected 13", c); end
      end
      if (c >= 14) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_busy_after@%0d: got %0d expected 0", c, busy); end
      end
      tick();
    end
    start = 1'b0;
    total += 3;
    if (n != 2)  begin bad++; $display("[TB] FAIL bp_pairs: got %0d expected 2", n); end
    if (nd != 1) begin bad++; $display("[TB] FAIL bp_done_count: got %0d expected 1", nd); end
    if (nv != 7) begin bad++; $display("[TB] FAIL bp_valid_cycles: got %0d expected 7", nv); end
  endtask

  // Reset in the second MUL, then a clean restart.
  task automatic test_abort();
    int nbad;
    nbad = 0;
    omega = 18'd3;
    count = 10'd4;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 7) begin
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL abort_pre_valid: got %0d expected 1", out_valid); end
        if (weight_2 !== 18'd27) begin bad++; $display("[TB] FAIL abort_pre_w2: got %0d expected 27", weight_2); end
      end
      if (c == 8) rst = 1'b1;
      tick();
    end
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid: got %0d expected 0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL abort_busy: got %0d expected 0", busy); end
    if (done !== 1'b0)      begin bad++; $display("[TB] FAIL abort_done: got %0d expected 0", done); end
    if (weight_1 !== 18'd0) begin bad++; $display("[TB] FAIL abort_w1: got %0d expected 0", weight_1); end
    if (weight_2 !== 18'd0) begin bad++; $display("[TB] FAIL abort_w2: got %0d expected 0", weight_2); end
    start = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_over_start: got %0d expected 0", busy); end
    rst = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid || done || busy) nbad++;
      tick();
    end
    total++;
    if (nbad != 0) begin bad++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", nbad); end
    omega = 18'd3;
    count = 10'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL restart_valid: got %0d expected 1", out_valid); end
    if (weight_1 !== 18'd1) begin bad++; $display("[TB] FAIL restart_w1: got %0d expected 1", weight_1); end
    if (weight_2 !== 18'd3) begin bad++; $display("[TB] FAIL restart_w2: got %0d expected 3", weight_2); end
    tick();
    if (done !== 1'b1)      begin bad++; $display("[TB] FAIL restart_done: got %0d expected 1", done); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    omega = '0;
    count = '0;
    out_ready = 1'b0;
    test_reset();

    exp_w1[0] = 1;  exp_w2[0] = 3;
    exp_w1[1] = 9;  exp_w2[1] = 27;
    exp_w1[2] = 81; exp_w2[2] = 243;
    test_stream("omega3", 3, 3);

    exp_w1[0] = 1;    exp_w2[0] = 128;
    exp_w1[1] = 4095; exp_w2[1] = 8022;
    test_stream("omega128", 128, 2);

    exp_w1[0] = 1; exp_w2[0] = 12288;
    exp_w1[1] = 1; exp_w2[1] = 12288;
    test_stream("omega_neg1", 12288, 2);

    exp_w1[0] = 1; exp_w2[0] = 3;
    test_stream("omega_wrap", 12292, 1);

    test_count_zero();
    test_backpressure();
    test_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
